// File: rtl/pop_pkg.sv
// Shared types and constants for the POP timing-chain checker.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pop_pkg;

    localparam int POP_WIDTH_DEF    = 16;
    localparam int POP_ERRCNT_W_DEF = 8;

    // Decoder FSM: one state per interval of the POP cycle, plus HUNT for
    // resynchronising after reset or an error.
    typedef enum logic [3:0] {
        ST_HUNT  = 4'd0,
        ST_PUMP  = 4'd1,
        ST_GAP1  = 4'd2,
        ST_PI1   = 4'd3,
        ST_FREEP = 4'd4,
        ST_PI2   = 4'd5,
        ST_GAP2  = 4'd6,
        ST_PROBE = 4'd7,
        ST_POST  = 4'd8
    } pop_state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_ORDER   = 3'd1;
    localparam logic [2:0] ERR_OVERLAP = 3'd2;
    localparam logic [2:0] ERR_SAMPLE  = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

endpackage

// File: rtl/pop_edge_detect.sv
// Two-stage register on one gate; lvl is the registered gate, rise/fall compare stages.
// Latency: lvl one cycle after the pin, rise/fall valid during that same cycle.
// Backpressure: none, free-running.
// Ports: clk, rst_n (async active-low), din (gate), lvl, rise, fall.
module pop_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic lvl_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl   <= 1'b0;
            lvl_d <= 1'b0;
        end else begin
            lvl   <= din;
            lvl_d <= lvl;
        end
    end

    assign rise = lvl & ~lvl_d;
    assign fall = ~lvl & lvl_d;

endmodule

// File: rtl/pop_sequence_decoder.sv
// Decodes pump/MW/probe/sample gates into interval widths; flags protocol violations.
// Latency: gate edges acted on 2 cycles after the pins; results publish on the pump rise closing a cycle.
// Backpressure: none; result_valid and seq_error are single-cycle strobes.
// Ports: clk_2M5, reset_n (async active-low); gates pump, MW, probe, sample;
//   result_valid + ten WIDTH-bit widths; seq_error, err_code, err_count; pi_mismatch.
// Optional: POP_PI_MATCH_CHECK_EN builds the pi1/pi2 width comparator behind pi_mismatch.
module pop_sequence_decoder
    import pop_pkg::*;
#(
    parameter int WIDTH    = POP_WIDTH_DEF,
    parameter int ERRCNT_W = POP_ERRCNT_W_DEF
) (
    input  logic                clk_2M5,
    input  logic                reset_n,
    input  logic                pump,
    input  logic                MW,
    input  logic                probe,
    input  logic                sample,
    output logic                result_valid,
    output logic [WIDTH-1:0]    pump_width,
    output logic [WIDTH-1:0]    gap1_width,
    output logic [WIDTH-1:0]    pi1_width,
    output logic [WIDTH-1:0]    freep_width,
    output logic [WIDTH-1:0]    pi2_width,
    output logic [WIDTH-1:0]    gap2_width,
    output logic [WIDTH-1:0]    probe_width,
    output logic [WIDTH-1:0]    sample_delay,
    output logic [WIDTH-1:0]    sample_width,
    output logic [WIDTH-1:0]    period,
    output logic                seq_error,
    output logic [2:0]          err_code,
    output logic [ERRCNT_W-1:0] err_count,
    output logic                pi_mismatch
);

    localparam logic [WIDTH-1:0]    CNT_MAX = {WIDTH{1'b1}};
    localparam logic [ERRCNT_W-1:0] ERR_MAX = {ERRCNT_W{1'b1}};

    logic p_q, p_r, p_f, m_q, m_r, m_f, r_q, r_r, r_f, s_q, s_r, s_f;

    pop_edge_detect u_ed_pump  (.clk(clk_2M5), .rst_n(reset_n), .din(pump),   .lvl(p_q), .rise(p_r), .fall(p_f));
    pop_edge_detect u_ed_mw    (.clk(clk_2M5), .rst_n(reset_n), .din(MW),     .lvl(m_q), .rise(m_r), .fall(m_f));
    pop_edge_detect u_ed_probe (.clk(clk_2M5), .rst_n(reset_n), .din(probe),  .lvl(r_q), .rise(r_r), .fall(r_f));
    pop_edge_detect u_ed_samp  (.clk(clk_2M5), .rst_n(reset_n), .din(sample), .lvl(s_q), .rise(s_r), .fall(s_f));

    pop_state_t state, ns;

    logic [WIDTH-1:0] pump_c, gap1_c, pi1_c, freep_c, pi2_c, gap2_c, probe_c, sdly_c, swid_c, per_c;
    logic             s_seen;   // sample rise already observed in this probe window

    // Bit order: {p_r, p_f, m_r, m_f, r_r, r_f}
    logic [5:0] edges, exp_mask;
    assign edges = {p_r, p_f, m_r, m_f, r_r, r_f};

    always_comb begin
        ns       = state;
        exp_mask = 6'b000000;
        case (state)
            ST_HUNT:  if (p_r) ns = ST_PUMP;
            ST_PUMP:  begin exp_mask = 6'b010000; if (p_f) ns = ST_GAP1;  end
            ST_GAP1:  begin exp_mask = 6'b001000; if (m_r) ns = ST_PI1;   end
            ST_PI1:   begin exp_mask = 6'b000100; if (m_f) ns = ST_FREEP; end
            ST_FREEP: begin exp_mask = 6'b001000; if (m_r) ns = ST_PI2;   end
            ST_PI2:   begin exp_mask = 6'b000100; if (m_f) ns = ST_GAP2;  end
            ST_GAP2:  begin exp_mask = 6'b000010; if (r_r) ns = ST_PROBE; end
            ST_PROBE: begin exp_mask = 6'b000001; if (r_f) ns = ST_POST;  end
            ST_POST:  begin exp_mask = 6'b100000; if (p_r) ns = ST_PUMP;  end
            default:  ns = ST_HUNT;
        endcase
    end

    logic active, overlap, order_hit, samp_bad, cnt_sat;
    logic e_order, e_overlap, e_sample, e_timeout, err_any, start, publish;
    logic [2:0] err_sel;

    assign active    = (state != ST_HUNT);
    assign overlap   = (p_q & m_q) | (p_q & r_q) | (m_q & r_q);
    assign order_hit = |(edges & ~exp_mask);
    // Sample may rise on the probe-rise edge and may fall on the probe-fall edge.
    assign samp_bad  = (s_r & ~((state == ST_PROBE) | ((state == ST_GAP2) & r_r)))
                     | (s_f & (state != ST_PROBE));
    assign cnt_sat   = (pump_c == CNT_MAX) | (gap1_c == CNT_MAX) | (pi1_c == CNT_MAX)
                     | (freep_c == CNT_MAX) | (pi2_c == CNT_MAX) | (gap2_c == CNT_MAX)
                     | (probe_c == CNT_MAX) | (sdly_c == CNT_MAX) | (swid_c == CNT_MAX)
                     | (per_c == CNT_MAX);

    // The edge that creates an overlap is reported as the overlap itself,
    // not additionally as an out-of-order edge.
    assign e_order   = active & order_hit & ~overlap;
    assign e_overlap = active & overlap;
    assign e_sample  = active & samp_bad;
    assign e_timeout = active & cnt_sat;
    assign err_any   = e_order | e_overlap | e_sample | e_timeout;
    assign err_sel   = e_order   ? ERR_ORDER   :
                       e_overlap ? ERR_OVERLAP :
                       e_sample  ? ERR_SAMPLE  : ERR_TIMEOUT;

    assign start   = p_r & ((state == ST_HUNT) | (state == ST_POST)) & ~err_any;
    assign publish = start & (state == ST_POST);

    always_ff @(posedge clk_2M5 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_HUNT;
            {pump_c, gap1_c, pi1_c, freep_c, pi2_c} <= '0;
            {gap2_c, probe_c, sdly_c, swid_c, per_c} <= '0;
            s_seen       <= 1'b0;
            result_valid <= 1'b0;
            {pump_width, gap1_width, pi1_width, freep_width, pi2_width} <= '0;
            {gap2_width, probe_width, sample_delay, sample_width, period} <= '0;
            seq_error    <= 1'b0;
            err_code     <= ERR_NONE;
            err_count    <= '0;
        end else begin
            result_valid <= 1'b0;
            seq_error    <= 1'b0;
            if (err_any) begin
                state     <= ST_HUNT;
                seq_error <= 1'b1;
                err_code  <= err_sel;
                if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
                {pump_c, gap1_c, pi1_c, freep_c, pi2_c} <= '0;
                {gap2_c, probe_c, sdly_c, swid_c, per_c} <= '0;
                s_seen    <= 1'b0;
            end else begin
                state <= ns;
                if (start) begin
                    if (publish) begin
                        result_valid <= 1'b1;
                        pump_width   <= pump_c;
                        gap1_width   <= gap1_c;
                        pi1_width    <= pi1_c;
                        freep_width  <= freep_c;
                        pi2_width    <= pi2_c;
                        gap2_width   <= gap2_c;
                        probe_width  <= probe_c;
                        sample_delay <= sdly_c;
                        sample_width <= swid_c;
                        period       <= per_c;
                    end
                    // The rise edge itself is the first pump cycle and the first period cycle.
                    {gap1_c, pi1_c, freep_c, pi2_c, gap2_c, probe_c, sdly_c, swid_c} <= '0;
                    pump_c <= {{(WIDTH-1){1'b0}}, 1'b1};
                    per_c  <= {{(WIDTH-1){1'b0}}, 1'b1};
                    s_seen <= 1'b0;
                end else if (active) begin
                    per_c <= per_c + 1'b1;
                    case (ns)
                        ST_PUMP:  pump_c  <= pump_c + 1'b1;
                        ST_GAP1:  gap1_c  <= gap1_c + 1'b1;
                        ST_PI1:   pi1_c   <= pi1_c + 1'b1;
                        ST_FREEP: freep_c <= freep_c + 1'b1;
                        ST_PI2:   pi2_c   <= pi2_c + 1'b1;
                        ST_GAP2:  gap2_c  <= gap2_c + 1'b1;
                        ST_PROBE: begin
                            probe_c <= probe_c + 1'b1;
                            if (s_q) swid_c <= swid_c + 1'b1;
                            // Delay stays 0 on the probe-rise edge and counts up to
                            // and including the edge on which sample rises.
                            if (state != ST_GAP2 && !s_seen) sdly_c <= sdly_c + 1'b1;
                            if (state == ST_GAP2 || !s_seen) s_seen <= s_r;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef POP_PI_MATCH_CHECK_EN
    always_ff @(posedge clk_2M5 or negedge reset_n) begin
        if (!reset_n)     pi_mismatch <= 1'b0;
        else if (publish) pi_mismatch <= (pi1_c != pi2_c);
    end
`else
    assign pi_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_pop_sequence_decoder.sv
`timescale 1ns/1ps
module tb_pop_sequence_decoder;

    logic        clk_2M5 = 1'b0;
    logic        reset_n;
    logic        pump, MW, probe, sample;
    logic        result_valid, seq_error, pi_mismatch;
    logic [15:0] pump_width, gap1_width, pi1_width, freep_width, pi2_width;
    logic [15:0] gap2_width, probe_width, sample_delay, sample_width, period;
    logic [2:0]  err_code;
    logic [7:0]  err_count;

    always #200 clk_2M5 = ~clk_2M5;

    pop_sequence_decoder #(.WIDTH(16), .ERRCNT_W(8)) dut (
        .clk_2M5(clk_2M5), .reset_n(reset_n),
        .pump(pump), .MW(MW), .probe(probe), .sample(sample),
        .result_valid(result_valid),
        .pump_width(pump_width), .gap1_width(gap1_width), .pi1_width(pi1_width),
        .freep_width(freep_width), .pi2_width(pi2_width), .gap2_width(gap2_width),
        .probe_width(probe_width), .sample_delay(sample_delay), .sample_width(sample_width),
        .period(period), .seq_error(seq_error), .err_code(err_code),
        .err_count(err_count), .pi_mismatch(pi_mismatch)
    );

    // One POP cycle: phase lengths driven, plus the expected period and pi mismatch.
    typedef struct {
        int pump; int gap1; int pi1; int freep; int pi2; int gap2;
        int probe; int sdly; int swid; int post;
        int per; int mm;
    } cyc_t;

    cyc_t sb_q[$];
    int   err_q[$];
    cyc_t tbl[4];
    cyc_t nom;
    cyc_t last_pub = '{default: 0};
    cyc_t mon_c;
    int   mon_code;
    int   model_cnt = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] g, input int n);
        {pump, MW, probe, sample} = g;
        repeat (n) @(posedge clk_2M5);
        #1;
    endtask

    task automatic drive_cycle(input cyc_t c, input bit push);
        hold(4'b1000, c.pump);
        hold(4'b0000, c.gap1);
        hold(4'b0100, c.pi1);
        hold(4'b0000, c.freep);
        hold(4'b0100, c.pi2);
        hold(4'b0000, c.gap2);
        for (int i = 0; i < c.probe; i++)
            hold({3'b001, (i >= c.sdly && i < c.sdly + c.swid)}, 1);
        hold(4'b0000, c.post);
        if (push) sb_q.push_back(c);
    endtask

    task automatic wait_err(input string name, input int bound);
        int n;
        n = 0;
        while (err_q.size() != 0 && n < bound) begin
            @(posedge clk_2M5);
            n++;
        end
        #1;
        if (err_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s: no seq_error within %0d cycles, expected code %0d", name, bound, err_q[0]);
            err_q.delete();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".result_valid"}, int'(result_valid), 0);
        chk({tag, ".pump_width"},   int'(pump_width), 0);
        chk({tag, ".gap1_width"},   int'(gap1_width), 0);
        chk({tag, ".pi1_width"},    int'(pi1_width), 0);
        chk({tag, ".freep_width"},  int'(freep_width), 0);
        chk({tag, ".pi2_width"},    int'(pi2_width), 0);
        chk({tag, ".gap2_width"},   int'(gap2_width), 0);
        chk({tag, ".probe_width"},  int'(probe_width), 0);
        chk({tag, ".sample_delay"}, int'(sample_delay), 0);
        chk({tag, ".sample_width"}, int'(sample_width), 0);
        chk({tag, ".period"},       int'(period), 0);
        chk({tag, ".seq_error"},    int'(seq_error), 0);
        chk({tag, ".err_code"},     int'(err_code), 0);
        chk({tag, ".err_count"},    int'(err_count), 0);
        chk({tag, ".pi_mismatch"},  int'(pi_mismatch), 0);
    endtask

    // Output monitor: publishes are popped from the result scoreboard, error
    // strobes from the error scoreboard.
    always @(negedge clk_2M5) begin
        if (!reset_n) begin
            model_cnt = 0;
            last_pub  = '{default: 0};
        end else begin
            if (result_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result_valid: got 1, expected 0 (period=%0d)", period);
                end else begin
                    mon_c = sb_q.pop_front();
                    chk("pub.pump_width",   int'(pump_width),   mon_c.pump);
                    chk("pub.gap1_width",   int'(gap1_width),   mon_c.gap1);
                    chk("pub.pi1_width",    int'(pi1_width),    mon_c.pi1);
                    chk("pub.freep_width",  int'(freep_width),  mon_c.freep);
                    chk("pub.pi2_width",    int'(pi2_width),    mon_c.pi2);
                    chk("pub.gap2_width",   int'(gap2_width),   mon_c.gap2);
                    chk("pub.probe_width",  int'(probe_width),  mon_c.probe);
                    chk("pub.sample_delay", int'(sample_delay), mon_c.sdly);
                    chk("pub.sample_width", int'(sample_width), mon_c.swid);
                    chk("pub.period",       int'(period),       mon_c.per);
`ifdef POP_PI_MATCH_CHECK_EN
                    chk("pub.pi_mismatch",  int'(pi_mismatch),  mon_c.mm);
`else
                    chk("pub.pi_mismatch",  int'(pi_mismatch),  0);
`endif
                    last_pub = mon_c;
                end
            end
            if (seq_error) begin
                if (err_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_seq_error: got code %0d, expected no error", err_code);
                end else begin
                    mon_code = err_q.pop_front();
                    if (model_cnt < 255) model_cnt++;
                    chk("err.err_code",     int'(err_code),     mon_code);
                    chk("err.err_count",    int'(err_count),    model_cnt);
                    chk("err.result_valid", int'(result_valid), 0);
                    chk("err.held_pump",    int'(pump_width),   last_pub.pump);
                    chk("err.held_period",  int'(period),       last_pub.per);
                end
            end
        end
    end

    initial begin
        #38000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        nom    = '{1000, 125, 1000, 7500, 1000, 125, 375, 0, 125, 500, 11625, 0};
        tbl[0] = '{20, 3, 12, 40, 12, 3, 15, 0, 15, 6, 111, 0};
        tbl[1] = '{8, 1, 10, 25, 11, 1, 9, 3, 4, 1, 66, 1};
        tbl[2] = '{1, 2, 1, 1, 1, 2, 4, 3, 1, 3, 15, 0};
        tbl[3] = '{30, 5, 1000, 50, 1025, 5, 20, 19, 1, 10, 2145, 1};

        reset_n = 1'b0;
        {pump, MW, probe, sample} = 4'b0000;
        repeat (3) @(posedge clk_2M5);
        #1;
        chk_all_zero("in_reset");
        reset_n = 1'b1;
        hold(4'b0000, 3);
        chk_all_zero("after_reset");

        // Nominal cycle; its results appear on the first table cycle's pump rise.
        drive_cycle(nom, 1'b1);
        for (int i = 0; i < 4; i++) drive_cycle(tbl[i], 1'b1);

        // MW rises while pump is high: this pump rise also publishes tbl[3].
        err_q.push_back(2);
        hold(4'b1000, 5);
        hold(4'b1100, 3);
        wait_err("overlap", 10);
        hold(4'b0000, 5);
        drive_cycle(tbl[0], 1'b1);
        drive_cycle(tbl[1], 1'b1);

        // Probe before the second MW pulse (pump rise publishes tbl[1]).
        err_q.push_back(1);
        hold(4'b1000, 10);
        hold(4'b0000, 2);
        hold(4'b0100, 10);
        hold(4'b0000, 5);
        hold(4'b0010, 4);
        wait_err("order", 10);
        hold(4'b0000, 5);

        // Sample pulse 10 cycles after probe falls.
        hold(4'b1000, 10);
        hold(4'b0000, 2);
        hold(4'b0100, 5);
        hold(4'b0000, 5);
        hold(4'b0100, 5);
        hold(4'b0000, 2);
        hold(4'b0010, 2);
        hold(4'b0011, 3);
        hold(4'b0010, 3);
        hold(4'b0000, 10);
        err_q.push_back(3);
        hold(4'b0001, 3);
        wait_err("sample", 10);
        hold(4'b0000, 5);

        // Pump stuck high: pump counter saturates.
        err_q.push_back(4);
        hold(4'b1000, 65600);
        wait_err("timeout", 10);
        hold(4'b0000, 5);

        // Reset in the middle of PI1.
        hold(4'b1000, 10);
        hold(4'b0000, 2);
        hold(4'b0100, 5);
        reset_n = 1'b0;
        #5;
        chk_all_zero("mid_reset");
        {pump, MW, probe, sample} = 4'b0000;
        @(posedge clk_2M5);
        #1;
        reset_n = 1'b1;
        hold(4'b0000, 3);

        // Clean cycle after reset, closed by one more pump rise.
        drive_cycle(tbl[2], 1'b1);
        hold(4'b1000, 6);
        hold(4'b0000, 4);

        chk("sb_drained",  sb_q.size(), 0);
        chk("err_drained", err_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
